// File: rtl/axis_fifo_arbiter_if.sv
// Handshake bundle between the per-channel FIFO outputs, the packet arbiter
// and the downstream demux/mux select logic.
interface axis_fifo_arbiter_if;
  logic [7:0] axis_out_tvalid;
  logic [7:0] axis_out_tlast;
  logic       axis_in_tready;
  logic [7:0] bus_sel;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic       pkt_done;
  logic       wdog_err;

  modport master (
    input  axis_out_tvalid, axis_out_tlast, axis_in_tready,
    output bus_sel, grant_valid, grant_idx, pkt_done, wdog_err
  );

  modport slave (
    output axis_out_tvalid, axis_out_tlast, axis_in_tready,
    input  bus_sel, grant_valid, grant_idx, pkt_done, wdog_err
  );
endinterface

// File: rtl/axis_fifo_arbiter.sv
// Round-robin packet arbiter over eight FIFOs; holds each grant for a whole packet.
// Define AXIS_ARB_WDOG_EN to build the stall watchdog that revokes a stuck grant.
module axis_fifo_arbiter #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_fifo_arbiter_if.master        bus
);

  if (WDOG_CYCLES < 2 || WDOG_CYCLES > 65535) begin : g_bad_wdog
    $error("WDOG_CYCLES out of range 2..65535");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [7:0] bus_sel_q, bus_sel_d;
  logic [2:0] last_q, last_d;
  logic [2:0] gidx;
  logic       beat, eop, wdog_fire;
  logic       req_found;
  logic [2:0] req_idx;

  assign gidx = bus_sel_q[2:0];
  assign beat = (state_q == BUSY) && bus.axis_out_tvalid[gidx] && bus.axis_in_tready;
  assign eop  = beat && bus.axis_out_tlast[gidx];

  // Scan last+1 .. last+8 (mod 8); the last-granted port has lowest priority.
  always_comb begin
    req_found = 1'b0;
    req_idx   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      if (!req_found && bus.axis_out_tvalid[last_q + 3'(i)]) begin
        req_found = 1'b1;
        req_idx   = last_q + 3'(i);
      end
    end
  end

`ifdef AXIS_ARB_WDOG_EN
  logic [15:0] wdog_cnt_q;

  // Fires on the stalled cycle whose increment brings the count to WDOG_CYCLES.
  assign wdog_fire = (state_q == BUSY) && !beat && (wdog_cnt_q == 16'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                          wdog_cnt_q <= '0;
    else if (state_q != BUSY || beat) wdog_cnt_q <= '0;
    else                              wdog_cnt_q <= wdog_cnt_q + 16'd1;
  end
`else
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bus_sel_q <= 8'd0;
      last_q    <= 3'd7;
    end else begin
      state_q   <= state_d;
      bus_sel_q <= bus_sel_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_found) state_d = BUSY;
      BUSY:    if (eop || wdog_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_sel_d    = bus_sel_q;
    last_d       = last_q;
    bus.pkt_done = 1'b0;
    bus.wdog_err = 1'b0;
    case (state_q)
      IDLE: begin
        bus_sel_d = 8'd0;
        if (req_found) begin
          bus_sel_d = {5'b10000, req_idx};
          last_d    = req_idx;
        end
      end
      BUSY: begin
        bus.pkt_done = eop;
        bus.wdog_err = wdog_fire;
        if (eop || wdog_fire) bus_sel_d = 8'd0;
      end
      default: bus_sel_d = 8'd0;
    endcase
  end

  assign bus.bus_sel     = bus_sel_q;
  assign bus.grant_valid = bus_sel_q[7];
  assign bus.grant_idx   = bus_sel_q[7] ? bus_sel_q[2:0] : 3'd0;

endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Scoreboard bench for axis_fifo_arbiter: expected grants are queued as
// stimulus is applied and popped as grants appear on bus_sel.
module tb_axis_fifo_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_fifo_arbiter_if ifc ();

  axis_fifo_arbiter #(.WDOG_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];

  int   bcnt[8];
  int   bad, ndone, hold, gap, ngrant, e;
  bit   prev_gv, rr_end;
  logic [2:0] gi;
`ifdef AXIS_ARB_WDOG_EN
  int   nstall;
  bit   wseen;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.axis_out_tvalid = 8'h00;
    ifc.axis_out_tlast  = 8'h00;
    ifc.axis_in_tready  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Pop the next expected port and wait (bounded) for its grant to show.
  task automatic wait_grant(input string tag, input int budget);
    int  ex;
    bit  seen;
    seen = 1'b0;
    ex   = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (ifc.grant_valid) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_sel"}, 32'(ifc.bus_sel), 32'(128 + ex));
      chk({tag, "_idx"}, 32'(ifc.grant_idx), 32'(ex));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state and first-grant latency
    do_reset();
    @(negedge clk);
    chk("rst_bus_sel", 32'(ifc.bus_sel), 32'd0);
    chk("rst_gvalid",  32'(ifc.grant_valid), 32'd0);
    chk("rst_gidx",    32'(ifc.grant_idx), 32'd0);
    chk("rst_pkt_done",32'(ifc.pkt_done), 32'd0);
    chk("rst_wdog",    32'(ifc.wdog_err), 32'd0);
    tick();
    ifc.axis_out_tvalid = 8'h01;
    ifc.axis_out_tlast  = 8'h01;
    ifc.axis_in_tready  = 1'b1;
    @(negedge clk);
    chk("first_pre", 32'(ifc.bus_sel), 32'd0);
    exp_q.push_back(0);
    wait_grant("first", 1);
    chk("first_done", 32'(ifc.pkt_done), 32'd1);
    tick();
    ifc.axis_out_tvalid = 8'h00;
    ifc.axis_out_tlast  = 8'h00;
    @(negedge clk);
    chk("first_bubble", 32'(ifc.bus_sel), 32'd0);

    // Round-robin, all requesting, 2-beat packets
    do_reset();
    ifc.axis_in_tready  = 1'b1;
    ifc.axis_out_tvalid = 8'hFF;
    for (int i = 0; i < 9; i++) exp_q.push_back(i % 8);
    for (int i = 0; i < 8; i++) bcnt[i] = 0;
    ndone = 0; hold = 0; gap = 0; ngrant = 0; prev_gv = 1'b0; rr_end = 1'b0;
    for (int cyc = 0; cyc < 200 && !rr_end; cyc++) begin
      gi = ifc.grant_idx;
      ifc.axis_out_tlast = (ifc.grant_valid && bcnt[gi] == 1) ? (8'h01 << gi) : 8'h00;
      @(negedge clk);
      if (ifc.grant_valid && !prev_gv) begin
        if (ngrant > 0) chk("rr_gap", 32'(gap), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("rr_sel", 32'(ifc.bus_sel), 32'(128 + e));
        hold = 0;
        ngrant++;
      end
      if (ifc.grant_valid) hold++; else gap++;
      if (ifc.grant_valid && !prev_gv) gap = 0;
      if (!ifc.grant_valid && prev_gv) begin
        chk("rr_hold", 32'(hold), 32'd2);
        gap = 1;
        if (exp_q.size() == 0) rr_end = 1'b1;
      end
      if (ifc.pkt_done) ndone++;
      if (ifc.grant_valid) bcnt[gi] = (bcnt[gi] == 1) ? 0 : bcnt[gi] + 1;
      prev_gv = ifc.grant_valid;
      tick();
    end
    chk("rr_end", 32'(rr_end), 32'd1);
    chk("rr_done_cnt", 32'(ndone), 32'd9);
    ifc.axis_out_tvalid = 8'h00;

    // Backpressure on FIFO 5
    do_reset();
    ifc.axis_out_tvalid = 8'h20;
    ifc.axis_out_tlast  = 8'h20;
    exp_q.push_back(5);
    wait_grant("bp", 4);
    bad = 0;
    repeat (20) begin
      tick();
      @(negedge clk);
      if (ifc.bus_sel != 8'd133 || ifc.pkt_done) bad++;
    end
    chk("bp_hold", 32'(bad), 32'd0);
    tick();
    ifc.axis_in_tready = 1'b1;
    @(negedge clk);
    chk("bp_done", 32'(ifc.pkt_done), 32'd1);
    tick();
    ifc.axis_out_tvalid = 8'h00;
    ifc.axis_out_tlast  = 8'h00;
    @(negedge clk);
    chk("bp_release", 32'(ifc.bus_sel), 32'd0);

    // Ungranted FIFOs ignored; next grants follow round-robin from last=2
    do_reset();
    ifc.axis_in_tready  = 1'b1;
    ifc.axis_out_tvalid = 8'h04;
    exp_q.push_back(2);
    wait_grant("ig2", 4);
    tick();
    ifc.axis_out_tvalid = 8'h44;
    ifc.axis_out_tlast  = 8'h40;
    @(negedge clk);
    chk("ig_other_sel",  32'(ifc.bus_sel), 32'd130);
    chk("ig_other_done", 32'(ifc.pkt_done), 32'd0);
    tick();
    ifc.axis_out_tvalid = 8'h04;
    ifc.axis_out_tlast  = 8'h04;
    @(negedge clk);
    chk("ig2_done", 32'(ifc.pkt_done), 32'd1);
    tick();
    ifc.axis_out_tvalid = 8'h48;
    ifc.axis_out_tlast  = 8'h48;
    exp_q.push_back(3);
    exp_q.push_back(6);
    wait_grant("ig_a", 4);
    chk("ig_a_done", 32'(ifc.pkt_done), 32'd1);
    tick();
    wait_grant("ig_b", 4);
    tick();
    ifc.axis_out_tvalid = 8'h00;
    ifc.axis_out_tlast  = 8'h00;

    // Reset mid-packet drops the grant and restores last=7
    do_reset();
    ifc.axis_in_tready  = 1'b1;
    ifc.axis_out_tvalid = 8'h10;
    exp_q.push_back(4);
    wait_grant("mr4", 4);
    tick();
    rst = 1'b1;
    ifc.axis_out_tvalid = 8'h30;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_clr_sel", 32'(ifc.bus_sel), 32'd0);
    chk("mr_clr_gv",  32'(ifc.grant_valid), 32'd0);
    exp_q.push_back(4);
    wait_grant("mr_re", 1);

    // Stalled grant on FIFO 3
    do_reset();
    ifc.axis_in_tready  = 1'b1;
    ifc.axis_out_tvalid = 8'h08;
    exp_q.push_back(3);
    wait_grant("wd3", 4);
    tick();
    ifc.axis_out_tvalid = 8'h10;
`ifdef AXIS_ARB_WDOG_EN
    nstall = 0; wseen = 1'b0; bad = 0;
    for (int c = 0; c < 64 && !wseen; c++) begin
      @(negedge clk);
      nstall++;
      if (ifc.bus_sel != 8'd131) bad++;
      if (ifc.wdog_err) wseen = 1'b1;
      else tick();
    end
    chk("wd_seen",  32'(wseen), 32'd1);
    chk("wd_stall", 32'(nstall), 32'd16);
    chk("wd_hold",  32'(bad), 32'd0);
    tick();
    ifc.axis_out_tvalid = 8'h18;
    @(negedge clk);
    chk("wd_rev_sel",  32'(ifc.bus_sel), 32'd0);
    chk("wd_rev_pulse",32'(ifc.wdog_err), 32'd0);
    exp_q.push_back(4);
    wait_grant("wd_next", 1);
`else
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (ifc.bus_sel != 8'd131 || ifc.wdog_err) bad++;
      tick();
    end
    chk("nowd_hold", 32'(bad), 32'd0);
    @(negedge clk);
    chk("nowd_sel", 32'(ifc.bus_sel), 32'd131);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
